instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Fetch stage that sits directly downstream of the PC register. It issues instruction-memory reads at the current PC and advances the PC register through its enable input. Fetched instructions are buffered in an in-order queue and handed to decode with a valid/ready handshake. A flush (branch/jump redirect) empties the queue and silently discards responses that are still in flight.

## Interface
- DEPTH, 4: instruction queue entries; also the maximum number of outstanding memory requests; power of two, ≥2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pc  in  32  current PC, driven by the PC register output.
- pc_enable  out  1  PC register load enable; high exactly on cycles where a request is accepted.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  request address; always equal to pc.
- imem_resp_valid  in  1  read data valid; responses return in order, latency ≥1 cycle.
- imem_resp_data  in  32  instruction word.
- flush  in  1  redirect; the PC register loads the target in the same cycle.
- dec_valid  out  1  queue head is valid.
- dec_ready  in  1  decode consumes the head.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  address the head instruction was fetched from.

## Operation
- Counters:
  - occ: queue occupancy, 0..DEPTH.
  - outst: requests accepted but not yet answered, 0..DEPTH.
  - drop: responses still to discard, 0..DEPTH.
- FSM states:
  - RUN: normal fetch.
  - DRAIN: discard stale responses; no requests are issued.
- Credit rule: imem_req_valid = (state==RUN) && !flush && !reset && (occ + outst < DEPTH).
- Request accept (imem_req_valid && imem_req_ready):
  - pc_enable=1.
  - pc is pushed into the pending-address FIFO.
  - outst increments.
- Response in RUN:
  - Pop the pending address.
  - Push {addr, imem_resp_data} into the instruction queue.
  - outst decrements.
- Response in DRAIN:
  - Pop the pending address and discard both.
  - outst and drop each decrement.
  - When drop reaches 0, go to RUN.
- Pop: dec_valid && dec_ready removes the head; occ decrements.
- Simultaneous push, pop, accept and response in one cycle are all legal; counters update by net delta.
- Flush takes priority over every other event in that cycle:
  - Instruction queue is emptied.
  - Any pop is ignored.
  - No request is issued.
  - A response arriving in the flush cycle is discarded.
  - drop = outst − resp_valid; the pending-address FIFO keeps only those entries.
  - If drop > 0, next state is DRAIN; otherwise RUN.
- Flush while already in DRAIN: recompute drop by the same rule; a further response arriving in that cycle is discarded.
- Protocol error: imem_resp_valid with outst==0 must not occur. The bench asserts on it; the RTL ignores the response.

## Timing
- Reset values:
  - occ=outst=drop=0, state=RUN.
  - dec_valid=0, dec_instr=0, dec_pc=0.
  - imem_req_valid=0 and pc_enable=0 while reset is high.
- First request is issued in the first cycle after reset deasserts, at address pc.
- Response-to-decode latency is 1 cycle: data captured at edge N is visible on dec_valid/dec_instr after edge N.
- No combinational path from imem_resp_valid or dec_ready to imem_req_valid or pc_enable within a cycle. Credit uses registered occ and outst only.
- Throughput: with 1-cycle memory and decode always ready, one request per cycle, steady state.
- Flush: dec_valid=0 from the cycle after flush until the first new response is captured.
- Reset mid-operation clears all state immediately. Responses arriving after release are treated as protocol errors; the bench must not drive them.

## Structure
- Shared package fetch_pkg holds:
  - INSTR_W=32, ADDR_W=32.
  - typedef fetch_entry_t {addr, instr}.
  - typedef fetch_state_t {RUN, DRAIN}.
- Sub-module sync_fifo: parameterised width and depth; push/pop/clear; full/empty/count outputs; asynchronous active-high reset.
- Instantiated twice:
  - pending-address FIFO, width 32.
  - instruction queue, width 64.
- FSM and counters live in the top module.

## Test plan
- Reset then free-run, 1-cycle memory, dec_ready=1, PC register advancing by +4 from 0: dec_pc sequence 0,4,8,… one per cycle; pc_enable high every cycle after the first.
- dec_ready=0, DEPTH=4, memory latency 3: exactly 4 requests accepted (0,4,8,12), then imem_req_valid=0; raising dec_ready resumes requests one cycle after occ falls below DEPTH.
- flush with 2 requests outstanding (addresses 0x10, 0x14), target 0x100: state DRAIN; both responses discarded; first dec_pc after flush is 0x100.
- flush in the same cycle a response arrives and outst=1: drop=0, state stays RUN; the next request is at the new PC one cycle later.
- imem_req_ready held low 5 cycles: pc_enable stays 0 and pc holds; imem_req_addr stays stable.
- reset asserted mid-stream with occ=3: dec_valid=0 immediately; after release, fetch restarts from the pc value at that point.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // RUN issues requests; DRAIN swallows responses that belong to a flushed path.
    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy outputs.
// Storage is reset to zero so an empty FIFO reads back zero after reset.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointer, count and storage update; clear wins over push and pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues imem reads at pc, buffers responses in order for decode,
// and discards in-flight responses after a redirect (flush).
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_enable,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               flush,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = $bits(fetch_entry_t);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [CNT_W-1:0]   drop;
    logic [CNT_W-1:0]   drop_next;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   outst;
    logic [CNT_W:0]     credit_sum;
    logic               has_credit;
    logic               pend_full;
    logic               pend_empty;
    logic [ADDR_W-1:0]  pend_addr;
    logic               iq_full;
    logic               iq_empty;
    logic               iq_push;
    logic               iq_pop;
    logic               resp_fire;
    fetch_entry_t       iq_in;
    fetch_entry_t       iq_head;
    logic [ENTRY_W-1:0] iq_head_bits;

    // Request credit looks only at registered occupancy so memory responses and
    // decode back-pressure never reach the request path combinationally.
    always_comb begin
        credit_sum     = {1'b0, occ} + {1'b0, outst};
        has_credit     = (credit_sum < (CNT_W + 1)'(DEPTH));
        imem_req_valid = (state == RUN) && !flush && !reset && has_credit && !pend_full;
        pc_enable      = imem_req_valid && imem_req_ready;
        imem_req_addr  = pc;
    end

    // Response routing: a response only counts if a request is outstanding; it
    // enters the queue in RUN and is dropped in DRAIN or during a flush.
    always_comb begin
        resp_fire = imem_resp_valid && !pend_empty;
        iq_push   = resp_fire && (state == RUN) && !flush && !iq_full;
        iq_pop    = dec_ready && !iq_empty && !flush;
        iq_in     = '{addr: pend_addr, instr: imem_resp_data};
    end

    // Addresses of requests still waiting for their response, oldest first.
    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (pc_enable),
        .push_data (pc),
        .pop       (resp_fire),
        .clear     (1'b0),
        .pop_data  (pend_addr),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (outst)
    );

    // Fetched instructions waiting for decode; a flush empties it outright.
    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (iq_push),
        .push_data (iq_in),
        .pop       (iq_pop),
        .clear     (flush),
        .pop_data  (iq_head_bits),
        .full      (iq_full),
        .empty     (iq_empty),
        .count     (occ)
    );

    // Decode sees the queue head directly.
    always_comb begin
        iq_head   = fetch_entry_t'(iq_head_bits);
        dec_valid = !iq_empty;
        dec_instr = iq_head.instr;
        dec_pc    = iq_head.addr;
    end

    // State and discard-count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            drop  <= '0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
        end
    end

    // On flush every request still unanswered after this cycle becomes stale;
    // DRAIN counts those down and returns to RUN when the last one is gone.
    always_comb begin
        state_next = state;
        drop_next  = drop;
        if (flush) begin
            drop_next  = outst - CNT_W'(resp_fire);
            state_next = (drop_next != '0) ? DRAIN : RUN;
        end else if ((state == DRAIN) && resp_fire) begin
            drop_next = drop - CNT_W'(1);
            if (drop_next == '0) begin
                state_next = RUN;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue against a queue-based
// reference model, with a PC register and an in-order memory modelled here.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_enable;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } expEnt_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    expEnt_t     modelQ[$];
    logic [31:0] pendQ[$];
    memReq_t     memQ[$];
    int          dropCnt;
    int          cyc;
    int          lastDue;
    int          latMin;
    int          latMax;
    int          checks;
    int          errors;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .pc_enable       (pc_enable),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .flush           (flush),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Instruction memory contents as a fixed scramble of the address.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Hold reset for two edges with the environment cleared, checking reset outputs.
    task automatic doReset(input logic [31:0] startPc);
        reset           = 1'b1;
        flush           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_req_ready  = 1'b0;
        dec_ready       = 1'b0;
        pc              = startPc;
        #1;
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_pc_enable", pc_enable, 0);
        checkOutput("rst_dec_valid", dec_valid, 0);
        checkOutput("rst_dec_instr", dec_instr, 0);
        checkOutput("rst_dec_pc",    dec_pc, 0);
        modelQ.delete();
        pendQ.delete();
        memQ.delete();
        dropCnt = 0;
        lastDue = -1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance
    // the model, memory and PC register by what this cycle should have done.
    task automatic applyStimulus(input logic fl, input logic [31:0] tgt, input logic dr, input logic rr);
        logic        respNow;
        logic [31:0] respAddr;
        logic [31:0] respData;
        logic        expReq;
        logic        accept;
        int          due;
        respNow  = (memQ.size() > 0) && (memQ[0].due <= cyc);
        respAddr = respNow ? memQ[0].addr : 32'h0;
        respData = respNow ? instrOf(respAddr) : $urandom;
        flush           = fl;
        dec_ready       = dr;
        imem_req_ready  = rr;
        imem_resp_valid = respNow;
        imem_resp_data  = respData;
        #2;
        expReq = !fl && (dropCnt == 0) && ((modelQ.size() + pendQ.size()) < DEPTH);
        accept = expReq && rr;
        checkOutput("req_valid", imem_req_valid, expReq);
        checkOutput("pc_enable", pc_enable, accept);
        checkOutput("req_addr",  imem_req_addr, pc);
        checkOutput("dec_valid", dec_valid, modelQ.size() > 0);
        if (modelQ.size() > 0) begin
            checkOutput("dec_pc",    dec_pc, modelQ[0].addr);
            checkOutput("dec_instr", dec_instr, modelQ[0].instr);
        end
        if (respNow) begin
            void'(memQ.pop_front());
        end
        if (fl) begin
            modelQ.delete();
            if (respNow && pendQ.size() > 0) begin
                void'(pendQ.pop_front());
            end
            dropCnt = pendQ.size();
        end else begin
            if (dr && modelQ.size() > 0) begin
                void'(modelQ.pop_front());
            end
            if (respNow && pendQ.size() > 0) begin
                if (dropCnt > 0) begin
                    void'(pendQ.pop_front());
                    dropCnt--;
                end else begin
                    modelQ.push_back('{addr: pendQ.pop_front(), instr: respData});
                end
            end
            if (accept) begin
                pendQ.push_back(pc);
                due = cyc + $urandom_range(latMax, latMin);
                if (due <= lastDue) begin
                    due = lastDue + 1;
                end
                lastDue = due;
                memQ.push_back('{addr: pc, due: due});
            end
        end
        @(posedge clock);
        #1;
        if (fl) begin
            pc = tgt;
        end else if (accept) begin
            pc = pc + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        lastDue = -1;
        dropCnt = 0;
        latMin  = 1;
        latMax  = 1;
        @(posedge clock);
        #1;

        // Free run: 1-cycle memory, decode always ready, PC from 0.
        doReset(32'h0);
        repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Decode stalled with 3-cycle memory: queue fills, then drains.
        doReset(32'h0);
        latMin = 3; latMax = 3;
        repeat (12) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Flush with two requests in flight (0x10, 0x14), redirect to 0x100.
        doReset(32'h10);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Flush in the cycle the only outstanding response returns.
        doReset(32'h40);
        latMin = 2; latMax = 2;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Memory not ready for 5 cycles: PC and request address hold.
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Reset mid-stream with three instructions queued.
        doReset(32'h0);
        latMin = 1; latMax = 1;
        for (int i = 0; i < 20 && modelQ.size() < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        end
        doReset(pc);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic with variable latency, back-pressure and redirects.
        latMin = 1; latMax = 4;
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(99, 0) < 5), $urandom & 32'hFFFF_FFFC,
                          ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
